imm_ext_arbiter: RTL and testbench
==================================

IMM_EXT_ARBITER -- requirements
Module: imm_ext_arbiter

Interface
REQ-001 Parameter IN_WIDTH, default 16, immediate field width.
REQ-002 Parameter OUT_WIDTH, default 32, extended result width; OUT_WIDTH > IN_WIDTH.
REQ-003 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port Req0Valid  input  1  requester 0 (decode) has an immediate to extend.
REQ-006 Port Req0Imm  input  IN_WIDTH  requester 0 immediate.
REQ-007 Port Req0Mode  input  2  requester 0 mode: 00 sign, 01 zero, 10 upper (LUI), 11 reserved.
REQ-008 Port Req0Ready  output  1  requester 0 request accepted this cycle when high with Req0Valid.
REQ-009 Ports Req1Valid, Req1Imm, Req1Mode, Req1Ready  same directions/widths/meanings as REQ-005..008, requester 1 (branch/address unit).
REQ-010 Port RespValid  output  1  RespData/RespId hold a valid result.
REQ-011 Port RespData  output  OUT_WIDTH  extended result.
REQ-012 Port RespId  output  1  requester that owns RespData.
REQ-013 Port RespReady  input  1  consumer takes the response when high with RespValid.

Function
REQ-014 States: IDLE (output register empty), HOLD (output register full).
REQ-015 Grant combinational: only one ReqNValid high -> grant that requester; both high -> grant requester indicated by round-robin pointer Ptr; none -> no grant.
REQ-016 ReqNReady = granted(N) AND (state==IDLE OR RespReady); never both ReqReady high in one cycle.
REQ-017 Accept = ReqNValid AND ReqNReady; on accept, next edge loads RespData = ext(ReqNImm, ReqNMode), RespId = N, RespValid = 1, state HOLD.
REQ-018 Latency exactly 1 cycle accept-to-RespValid; sustained throughput 1 result/cycle when RespReady held high.
REQ-019 HOLD with RespReady low: RespValid, RespData, RespId stable; no accept.
REQ-020 HOLD with RespReady high and no accept: next edge RespValid = 0, state IDLE; RespData/RespId retain last value.
REQ-021 HOLD with RespReady high and accept in same cycle: response replaced by new result, RespValid stays 1.
REQ-022 Ptr updates only on accept: Ptr <= ~N (other requester); no change otherwise.
REQ-023 Sign mode: OUT_WIDTH-IN_WIDTH copies of Imm[IN_WIDTH-1] concatenated above Imm.
REQ-024 Zero mode: OUT_WIDTH-IN_WIDTH zeros above Imm.
REQ-025 Reserved mode 11: treated as sign mode.
REQ-026 Requester inputs sampled only on accept; block does not check stability while Valid and not Ready.

Reset
REQ-027 rst_n low asynchronously forces state IDLE, RespValid 0, RespData 0, RespId 0, Ptr 0, regardless of clk.
REQ-028 Reset mid-HOLD discards the pending response; no response appears after release until a new accept.
REQ-029 ReqNReady low while rst_n low; first accept possible in first rising edge with rst_n high.

Configuration
REQ-030 Macro IMM_EXT_LUI_EN defined: upper mode 10 yields {Imm, (OUT_WIDTH-IN_WIDTH) zeros} (requires OUT_WIDTH >= 2*IN_WIDTH, else treated as sign mode).
REQ-031 Macro IMM_EXT_LUI_EN undefined: mode 10 treated as sign mode; no upper-shift logic instantiated.

Verification
REQ-032 Req0 only, Imm 16'h8004, mode 00, RespReady 1 -> next cycle RespValid 1, RespData 32'hFFFF8004, RespId 0.
REQ-033 Req1 only, Imm 16'h8004, mode 01 -> RespData 32'h00008004, RespId 1; mode 10 with IMM_EXT_LUI_EN -> 32'h80040000, without -> 32'hFFFF8004.
REQ-034 Both valid every cycle after reset, RespReady 1, Req0Imm 16'h0001, Req1Imm 16'h0002 -> RespId sequence 0,1,0,1, results 1,2,1,2, one per cycle.
REQ-035 Accept Req0 16'h7FFF, hold RespReady 0 for 3 cycles with Req1Valid 1 -> RespData 32'h00007FFF stable, Req1Ready 0; RespReady 1 -> Req1 accepted same cycle, next RespId 1.
REQ-036 rst_n low asynchronously mid-cycle while HOLD -> RespValid 0, RespData 0 immediately; after release with no requests RespValid remains 0.

Source files
------------

// File: rtl/imm_ext_arbiter.sv
// -----------------------------------------------------------------------------
// imm_ext_arbiter
//
// Purpose:
//   Two-requester round-robin arbiter in front of a single immediate-extension
//   unit. The granted requester's immediate is extended (sign, zero or upper)
//   and placed in a one-entry output register. The result appears one cycle
//   after acceptance. The output register can be refilled in the same cycle
//   that the consumer drains it, which gives one result per cycle.
//
// Parameters:
//   IN_WIDTH   immediate field width (default 16)
//   OUT_WIDTH  extended result width (default 32), must exceed IN_WIDTH
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   Req0Valid/Imm/Mode/Ready     requester 0 (decode) handshake and payload
//   Req1Valid/Imm/Mode/Ready     requester 1 (branch/address) handshake
//   RespValid/Data/Id/Ready      response handshake towards the consumer
//
// Mode encoding: 00 sign, 01 zero, 10 upper (LUI), 11 reserved (as sign).
//
// Configuration:
//   IMM_EXT_LUI_EN  when defined, mode 10 produces {Imm, zeros}. This applies
//                   only if OUT_WIDTH >= 2*IN_WIDTH. Otherwise, and in the
//                   default build, mode 10 behaves as sign extension.
// -----------------------------------------------------------------------------
module imm_ext_arbiter #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic                 Req0Valid,
    input  logic [IN_WIDTH-1:0]  Req0Imm,
    input  logic [1:0]           Req0Mode,
    output logic                 Req0Ready,

    input  logic                 Req1Valid,
    input  logic [IN_WIDTH-1:0]  Req1Imm,
    input  logic [1:0]           Req1Mode,
    output logic                 Req1Ready,

    output logic                 RespValid,
    output logic [OUT_WIDTH-1:0] RespData,
    output logic                 RespId,
    input  logic                 RespReady
);

    // Output register occupancy.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    localparam int EXT_W = OUT_WIDTH - IN_WIDTH;

`ifdef IMM_EXT_LUI_EN
    // The upper shift is only meaningful when the whole immediate fits above
    // a zero field at least as wide as itself.
    localparam bit LUI_OK = (OUT_WIDTH >= 2 * IN_WIDTH);
`endif

    // -------------------------------------------------------------------------
    // Extension function: sign extension is the fallback for every mode that
    // is not explicitly handled (reserved, and upper when disabled).
    // -------------------------------------------------------------------------
    function automatic logic [OUT_WIDTH-1:0] ext_imm(
        input logic [IN_WIDTH-1:0] imm,
        input logic [1:0]          mode
    );
        logic [OUT_WIDTH-1:0] r;
        r = {{EXT_W{imm[IN_WIDTH-1]}}, imm};
        case (mode)
            2'b01: r = {{EXT_W{1'b0}}, imm};
`ifdef IMM_EXT_LUI_EN
            2'b10: begin
                if (LUI_OK) begin
                    r = {imm, {EXT_W{1'b0}}};
                end
            end
`endif
            default: begin
            end
        endcase
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [0:0]           state_q, state_d;
    logic                 ptr_q, ptr_d;
    logic [OUT_WIDTH-1:0] resp_data_q, resp_data_d;
    logic                 resp_id_q, resp_id_d;

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
    logic gnt0;
    logic gnt1;
    logic can_load;
    logic acc0;
    logic acc1;

    // A lone requester always wins. On contention, the pointer picks the
    // winner, so the two grants are mutually exclusive by construction.
    assign gnt0 = Req0Valid & (~Req1Valid | ~ptr_q);
    assign gnt1 = Req1Valid & (~Req0Valid | ptr_q);

    // The register can take a new result when it is empty, or when it is
    // being drained in this same cycle.
    assign can_load = (state_q == ST_IDLE) | RespReady;

    // rst_n gates the readies, so no handshake completes while reset is asserted.
    assign Req0Ready = rst_n & gnt0 & can_load;
    assign Req1Ready = rst_n & gnt1 & can_load;

    assign acc0 = Req0Valid & Req0Ready;
    assign acc1 = Req1Valid & Req1Ready;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        resp_data_d = resp_data_q;
        resp_id_d   = resp_id_q;

        if (acc0) begin
            state_d     = ST_HOLD;
            resp_data_d = ext_imm(Req0Imm, Req0Mode);
            resp_id_d   = 1'b0;
            ptr_d       = 1'b1;
        end else if (acc1) begin
            state_d     = ST_HOLD;
            resp_data_d = ext_imm(Req1Imm, Req1Mode);
            resp_id_d   = 1'b1;
            ptr_d       = 1'b0;
        end else if ((state_q == ST_HOLD) && RespReady) begin
            // Drained with no refill: data and id keep their last value.
            state_d = ST_IDLE;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= 1'b0;
            resp_data_q <= '0;
            resp_id_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            resp_data_q <= resp_data_d;
            resp_id_q   <= resp_id_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign RespValid = (state_q == ST_HOLD);
    assign RespData  = resp_data_q;
    assign RespId    = resp_id_q;

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// -----------------------------------------------------------------------------
// tb_imm_ext_arbiter
//
// Self-checking bench for imm_ext_arbiter (IN_WIDTH 16, OUT_WIDTH 32).
//
// The bench holds a transaction-level reference model. The model tracks one
// pending response slot and a "whose turn" bit. A compare process checks every
// DUT output against the model on each falling clock edge. A set of directed
// scenarios uses hand-computed literals to pin the model itself. A randomized
// phase follows the directed scenarios.
//
// Build with +define+IMM_EXT_LUI_EN to exercise the upper mode.
// -----------------------------------------------------------------------------
module tb_imm_ext_arbiter;

    logic        clk;
    logic        rst_n;
    logic        Req0Valid;
    logic [15:0] Req0Imm;
    logic [1:0]  Req0Mode;
    logic        Req0Ready;
    logic        Req1Valid;
    logic [15:0] Req1Imm;
    logic [1:0]  Req1Mode;
    logic        Req1Ready;
    logic        RespValid;
    logic [31:0] RespData;
    logic        RespId;
    logic        RespReady;

    int n_tests;
    int n_fail;

    imm_ext_arbiter #(.IN_WIDTH(16), .OUT_WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Req0Valid (Req0Valid),
        .Req0Imm   (Req0Imm),
        .Req0Mode  (Req0Mode),
        .Req0Ready (Req0Ready),
        .Req1Valid (Req1Valid),
        .Req1Imm   (Req1Imm),
        .Req1Mode  (Req1Mode),
        .Req1Ready (Req1Ready),
        .RespValid (RespValid),
        .RespData  (RespData),
        .RespId    (RespId),
        .RespReady (RespReady)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------------
    // Reference model
    // ---------------------------------------------------------------------
    bit          m_full;   // a result is waiting for the consumer
    bit [31:0]   m_data;
    bit          m_id;
    bit          m_turn;   // requester favoured on contention

    function automatic bit [31:0] model_ext(input bit [15:0] imm, input bit [1:0] mode);
        logic signed [15:0] s;
        s = imm;
        if (mode == 2'd1) return {16'd0, imm};
`ifdef IMM_EXT_LUI_EN
        if (mode == 2'd2) return 32'(imm) * 32'd65536;
`endif
        return 32'(s);
    endfunction

    // The winner is the only active requester, or the favoured one when both are active.
    function automatic bit model_ready(input int n);
        bit v0, v1, winner_ok;
        v0 = Req0Valid;
        v1 = Req1Valid;
        if (n == 0) winner_ok = v0 && (!v1 || m_turn == 1'b0);
        else        winner_ok = v1 && (!v0 || m_turn == 1'b1);
        return rst_n && winner_ok && (!m_full || RespReady);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_full = 1'b0;
            m_data = 32'd0;
            m_id   = 1'b0;
            m_turn = 1'b0;
        end else begin
            if (model_ready(0)) begin
                m_data = model_ext(Req0Imm, Req0Mode);
                m_id   = 1'b0;
                m_full = 1'b1;
                m_turn = 1'b1;
            end else if (model_ready(1)) begin
                m_data = model_ext(Req1Imm, Req1Mode);
                m_id   = 1'b1;
                m_full = 1'b1;
                m_turn = 1'b0;
            end else if (RespReady) begin
                m_full = 1'b0;
            end
        end
    end

    // One compare process, away from the active edge.
    always @(negedge clk) begin
        chk("model RespValid", 32'(RespValid), 32'(m_full));
        chk("model RespData",  RespData, m_data);
        chk("model RespId",    32'(RespId), 32'(m_id));
        chk("model Req0Ready", 32'(Req0Ready), 32'(model_ready(0)));
        chk("model Req1Ready", 32'(Req1Ready), 32'(model_ready(1)));
    end

    // ---------------------------------------------------------------------
    // Stimulus helpers
    // ---------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        Req0Valid = 1'b0; Req0Imm = 16'h0; Req0Mode = 2'd0;
        Req1Valid = 1'b0; Req1Imm = 16'h0; Req1Mode = 2'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        RespReady = 1'b1;
        idle_inputs();
        rst_n = 1'b0;
        #2;
        chk("reset RespValid", 32'(RespValid), 32'd0);
        chk("reset RespData",  RespData, 32'd0);
        chk("reset Req0Ready", 32'(Req0Ready), 32'd0);
        step();
        rst_n = 1'b1;

        // Requester 0 sign-extends a negative immediate.
        Req0Valid = 1'b1; Req0Imm = 16'h8004; Req0Mode = 2'd0;
        step();
        idle_inputs();
        chk("r0 sign valid", 32'(RespValid), 32'd1);
        chk("r0 sign data",  RespData, 32'hFFFF8004);
        chk("r0 sign id",    32'(RespId), 32'd0);

        // Requester 1 zero mode, then upper mode.
        Req1Valid = 1'b1; Req1Imm = 16'h8004; Req1Mode = 2'd1;
        step();
        chk("r1 zero data", RespData, 32'h00008004);
        chk("r1 zero id",   32'(RespId), 32'd1);
        Req1Mode = 2'd2;
        step();
`ifdef IMM_EXT_LUI_EN
        chk("r1 upper data", RespData, 32'h80040000);
`else
        chk("r1 upper data", RespData, 32'hFFFF8004);
`endif
        Req1Mode = 2'd3;
        step();
        chk("r1 reserved data", RespData, 32'hFFFF8004);
        idle_inputs();
        step();
        chk("drain to idle", 32'(RespValid), 32'd0);
        chk("drain keeps data", RespData, 32'hFFFF8004);

        // Contention alternates fairly, one result per cycle.
        do_reset();
        Req0Valid = 1'b1; Req0Imm = 16'h0001;
        Req1Valid = 1'b1; Req1Imm = 16'h0002;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rr valid", 32'(RespValid), 32'd1);
            chk("rr id",    32'(RespId), 32'(i % 2));
            chk("rr data",  RespData, (i % 2 == 0) ? 32'd1 : 32'd2);
        end
        idle_inputs();

        // Back-pressure holds the response and blocks the other requester.
        do_reset();
        RespReady = 1'b0;
        Req0Valid = 1'b1; Req0Imm = 16'h7FFF; Req0Mode = 2'd0;
        step();
        Req0Valid = 1'b0;
        Req1Valid = 1'b1; Req1Imm = 16'h0002; Req1Mode = 2'd1;
        for (int i = 0; i < 3; i++) begin
            chk("bp Req1Ready", 32'(Req1Ready), 32'd0);
            chk("bp data", RespData, 32'h00007FFF);
            chk("bp valid", 32'(RespValid), 32'd1);
            step();
        end
        RespReady = 1'b1;
        #1;
        chk("bp release Req1Ready", 32'(Req1Ready), 32'd1);
        step();
        idle_inputs();
        chk("bp next id",   32'(RespId), 32'd1);
        chk("bp next data", RespData, 32'h00000002);

        // An asynchronous reset in the middle of HOLD discards the response.
        Req0Valid = 1'b1; Req0Imm = 16'h1234; Req0Mode = 2'd1;
        step();
        idle_inputs();
        RespReady = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst valid", 32'(RespValid), 32'd0);
        chk("async rst data",  RespData, 32'd0);
        step();
        rst_n = 1'b1;
        RespReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post rst quiet", 32'(RespValid), 32'd0);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            Req0Valid = 1'($urandom_range(0, 1));
            Req0Imm   = 16'($urandom);
            Req0Mode  = 2'($urandom);
            Req1Valid = 1'($urandom_range(0, 1));
            Req1Imm   = 16'($urandom);
            Req1Mode  = 2'($urandom);
            RespReady = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 199) == 0) begin
                #2 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
            step();
        end

        idle_inputs();
        RespReady = 1'b1;
        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
